// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared constants, state encoding and payload types for axi_lite_master
package axi_lite_pkg;

  localparam int AXIL_ADDR_WIDTH = 8;
  localparam int AXIL_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RSP     = 3'd5
  } axil_state_e;

  typedef struct packed {
    logic                           write;
    logic [AXIL_ADDR_WIDTH-1:0]     addr;
    logic [AXIL_DATA_WIDTH-1:0]     wdata;
    logic [AXIL_DATA_WIDTH/8-1:0]   wstrb;
  } axil_cmd_t;

  typedef struct packed {
    logic                           write;
    logic [AXIL_DATA_WIDTH-1:0]     rdata;
    logic                           err;
  } axil_rsp_t;

endpackage

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - command-driven single-outstanding AXI-Lite master
// Optional watchdog enabled by defining AXIL_TIMEOUT_EN.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = AXIL_ADDR_WIDTH,
  parameter int DATA_WIDTH     = AXIL_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA
);

  localparam logic [2:0] IDLE    = ST_IDLE;
  localparam logic [2:0] WR_AW_W = ST_WR_AW_W;
  localparam logic [2:0] WR_B    = ST_WR_B;
  localparam logic [2:0] RD_AR   = ST_RD_AR;
  localparam logic [2:0] RD_R    = ST_RD_R;
  localparam logic [2:0] RSP     = ST_RSP;

  logic [2:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    write_q, write_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    timeout;

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign AWVALID   = (state_q == WR_AW_W) && !aw_done_q;
  assign WVALID    = (state_q == WR_AW_W) && !w_done_q;
  assign BREADY    = (state_q == WR_AW_W) || (state_q == WR_B);
  assign ARVALID   = (state_q == RD_AR);
  assign RREADY    = (state_q == RD_R);
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;

  assign waiting = (state_q == WR_AW_W) || (state_q == WR_B) ||
                   (state_q == RD_AR)   || (state_q == RD_R);
  assign timeout = waiting && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Restart the count on every state change so each wait phase gets a full budget.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!waiting || (state_d != state_q)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  // Without the watchdog the block waits indefinitely; TIMEOUT_CYCLES has no effect.
  assign timeout = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b0;
          state_d   = cmd_write ? WR_AW_W : RD_AR;
        end
      end
      WR_AW_W: begin
        aw_done_d = aw_done_q || (AWVALID && AWREADY);
        w_done_d  = w_done_q  || (WVALID && WREADY);
        // BREADY is already high here, so a B beat at the completing edge is consumed now.
        if (aw_done_d && w_done_d) begin
          state_d = BVALID ? RSP : WR_B;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RSP;
        end
      end
      WR_B: begin
        if (BVALID) state_d = RSP;
        else if (timeout) begin
          err_d   = 1'b1;
          state_d = RSP;
        end
      end
      RD_AR: begin
        if (ARREADY) state_d = RD_R;
        else if (timeout) begin
          err_d   = 1'b1;
          state_d = RSP;
        end
      end
      RD_R: begin
        if (RVALID) begin
          rdata_d = RDATA;
          state_d = RSP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule
